// File: rtl/mult_adder_pkg.sv
// mult_adder_pkg: shared widths, result limits and the result saturation helper
package mult_adder_pkg;
  localparam int OPR_W = 8;
  localparam int PROD_W = 16;
  localparam int RES_W = 15;
  localparam int SUM_W = 23;
  localparam int RES_MAX = 16383;
  localparam int RES_MIN = -16384;
  localparam int PIPE_LAT = 5;
  typedef struct packed {
    logic overflow;
    logic [RES_W-1:0] result;
  } sat_t;
  function automatic sat_t sat_res(input logic signed [63:0] v);
    sat_t s;
    s.overflow = (v > 64'(RES_MAX)) || (v < 64'(RES_MIN));
    s.result = v > 64'(RES_MAX) ? RES_W'(RES_MAX) : v < 64'(RES_MIN) ? RES_W'(RES_MIN) : v[RES_W-1:0];
    return s;
  endfunction
endpackage

// File: rtl/mult_adder_tree2.sv
// mult_adder_tree2: two registered pairwise adder levels, N signed inputs -> N/4 sums
// Ports: clk, iRst (sync active-high), ena (0 holds every register),
//   in_valid/in_first/in_last + in_data (N x IN_W) in,
//   out_valid/out_first/out_last + out_data (N/4 x IN_W+2) out.
module mult_adder_tree2 #(
  parameter int N = 128,
  parameter int IN_W = 16
) (
  input  logic                        clk,
  input  logic                        iRst,
  input  logic                        ena,
  input  logic                        in_valid,
  input  logic                        in_first,
  input  logic                        in_last,
  input  logic [N*IN_W-1:0]           in_data,
  output logic                        out_valid,
  output logic                        out_first,
  output logic                        out_last,
  output logic [(N/4)*(IN_W+2)-1:0]   out_data
);
  localparam int M = N / 4;
  localparam int OW = IN_W + 2;
  logic [M*OW-1:0] sum, data_d, data_q;
  logic valid_d, valid_q, first_d, first_q, last_d, last_q;
  for (genvar g = 0; g < M; g++) begin : g_sum
    logic signed [IN_W:0] p0, p1;
    assign p0 = (IN_W+1)'(signed'(in_data[(4*g)*IN_W +: IN_W])) + (IN_W+1)'(signed'(in_data[(4*g+1)*IN_W +: IN_W]));
    assign p1 = (IN_W+1)'(signed'(in_data[(4*g+2)*IN_W +: IN_W])) + (IN_W+1)'(signed'(in_data[(4*g+3)*IN_W +: IN_W]));
    assign sum[g*OW +: OW] = OW'(p0) + OW'(p1);
  end
  always_comb begin
    valid_d = ena ? in_valid : valid_q;
    first_d = ena ? in_first : first_q;
    last_d = ena ? in_last : last_q;
    data_d = ena ? sum : data_q;
  end
  always_ff @(posedge clk) begin
    if (iRst) begin
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
    end else begin
      valid_q <= valid_d;
      first_q <= first_d;
      last_q <= last_d;
      data_q <= data_d;
    end
  end
  assign out_valid = valid_q;
  assign out_first = first_q;
  assign out_last = last_q;
  assign out_data = data_q;
endmodule

// File: rtl/mult_adder_pipe.sv
// mult_adder_pipe: 5-stage signed dot-product engine with multi-beat accumulation and saturated result
// Ports: clk, iRst (sync active-high), ena (0 freezes all stages),
//   in_valid/in_first/in_last framing, opr1/opr2 (LANES x 8-bit signed),
//   result (15-bit signed, saturated), overflow, out_valid (pulse), busy.
// Build option: MULT_ADDER_RELU_EN clamps negative results to 0 after saturation.
module mult_adder_pipe
  import mult_adder_pkg::*;
#(
  parameter int LANES = 128,
  parameter int FRAC_SHIFT = 0,
  parameter int ACC_W = 32
) (
  input  logic                   clk,
  input  logic                   iRst,
  input  logic                   ena,
  input  logic                   in_valid,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic [LANES*OPR_W-1:0] opr1,
  input  logic [LANES*OPR_W-1:0] opr2,
  output logic [RES_W-1:0]       result,
  output logic                   overflow,
  output logic                   out_valid,
  output logic                   busy
);
  localparam int W2 = PROD_W + 2;
  localparam int W3 = PROD_W + 4;
  localparam int W4 = PROD_W + 6;
  logic [LANES*PROD_W-1:0] prod, s1_prod_d, s1_prod_q;
  logic s1_valid_d, s1_valid_q, s1_first_d, s1_first_q, s1_last_d, s1_last_q;
  logic s2_valid, s2_first, s2_last, s3_valid, s3_first, s3_last, s4_valid, s4_first, s4_last;
  logic [(LANES/4)*W2-1:0] s2_data;
  logic [(LANES/16)*W3-1:0] s3_data;
  logic [(LANES/64)*W4-1:0] s4_data;
  logic signed [SUM_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_sum, acc_d, acc_q;
  logic step, emit, open_d, open_q, s5_valid_d, s5_valid_q;
  logic overflow_d, overflow_q, out_valid_d, out_valid_q;
  logic [RES_W-1:0] res_v, result_d, result_q;
  sat_t sat;
  for (genvar i = 0; i < LANES; i++) begin : g_mul
    assign prod[i*PROD_W +: PROD_W] = PROD_W'(signed'(opr1[i*OPR_W +: OPR_W])) * PROD_W'(signed'(opr2[i*OPR_W +: OPR_W]));
  end
  always_comb begin
    s1_valid_d = ena ? in_valid : s1_valid_q;
    s1_first_d = ena ? in_first : s1_first_q;
    s1_last_d = ena ? in_last : s1_last_q;
    s1_prod_d = ena ? prod : s1_prod_q;
  end
  mult_adder_tree2 #(.N(LANES), .IN_W(PROD_W)) u_s2 (
    .clk(clk), .iRst(iRst), .ena(ena), .in_valid(s1_valid_q), .in_first(s1_first_q), .in_last(s1_last_q),
    .in_data(s1_prod_q), .out_valid(s2_valid), .out_first(s2_first), .out_last(s2_last), .out_data(s2_data));
  mult_adder_tree2 #(.N(LANES/4), .IN_W(W2)) u_s3 (
    .clk(clk), .iRst(iRst), .ena(ena), .in_valid(s2_valid), .in_first(s2_first), .in_last(s2_last),
    .in_data(s2_data), .out_valid(s3_valid), .out_first(s3_first), .out_last(s3_last), .out_data(s3_data));
  mult_adder_tree2 #(.N(LANES/16), .IN_W(W3)) u_s4 (
    .clk(clk), .iRst(iRst), .ena(ena), .in_valid(s3_valid), .in_first(s3_first), .in_last(s3_last),
    .in_data(s3_data), .out_valid(s4_valid), .out_first(s4_first), .out_last(s4_last), .out_data(s4_data));
  always_comb begin
    sum = '0;
    for (int k = 0; k < LANES / 64; k++) sum = sum + SUM_W'(signed'(s4_data[k*W4 +: W4]));
    acc_sum = s4_first ? ACC_W'(sum) : acc_q + ACC_W'(sum);
    step = ena && s4_valid;
    emit = step && s4_last;
    // the accumulator restarts from 0 once a result has been emitted
    acc_d = step ? (s4_last ? '0 : acc_sum) : acc_q;
    open_d = step ? !s4_last : open_q;
    s5_valid_d = ena ? s4_valid : s5_valid_q;
    sat = sat_res(64'(acc_sum >>> FRAC_SHIFT));
`ifdef MULT_ADDER_RELU_EN
    res_v = sat.result[RES_W-1] ? '0 : sat.result;
`else
    res_v = sat.result;
`endif
    result_d = emit ? res_v : result_q;
    overflow_d = emit ? sat.overflow : overflow_q;
    out_valid_d = ena ? emit : out_valid_q;
  end
  always_ff @(posedge clk) begin
    if (iRst) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q <= 1'b0;
      s1_prod_q <= '0;
      s5_valid_q <= 1'b0;
      acc_q <= '0;
      open_q <= 1'b0;
      result_q <= '0;
      overflow_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_first_q <= s1_first_d;
      s1_last_q <= s1_last_d;
      s1_prod_q <= s1_prod_d;
      s5_valid_q <= s5_valid_d;
      acc_q <= acc_d;
      open_q <= open_d;
      result_q <= result_d;
      overflow_q <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign result = result_q;
  assign overflow = overflow_q;
  assign out_valid = out_valid_q;
  assign busy = s1_valid_q | s2_valid | s3_valid | s4_valid | s5_valid_q | open_q;
endmodule
